read_feeder: RTL and testbench

- Upstream stage of systolic_array.
- Accepts one read pair (reference, experimental, quality) as a load stream and buffers it on chip.
- Converts each phred quality to 64-bit double match/neq priors at load time.
- Serves systolic_array's read_index_x/read_index_y requests with registered READS/PRIORS, and holds the array in reset until a complete pair is loaded.

---
 rtl/read_feeder_pkg.sv | 64 ++++++
 rtl/read_feeder_if.sv | 44 ++++
 rtl/read_feeder_phred_rom.sv | 37 +++
 rtl/read_feeder.sv | 191 +++++++++++++++++++
 tb/tb_read_feeder.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/read_feeder_pkg.sv
// read_feeder_pkg: types and constants shared by read_feeder, its phred ROM,
// its bus interface and the systolic_array that consumes its outputs.
//   STRING          - base alphabet (A, C, G, T, and DASH for "no base")
//   READS / PRIORS  - registered request results handed to systolic_array
//   feeder_state_t  - load/serve sequencing states of read_feeder
//   QUAL_W          - width of a clamped phred value
//   neq_bits / match_bits - elaboration-time double conversions for the ROM

`ifndef MAX_STRING_LENGTH
`define MAX_STRING_LENGTH 16
`endif
`ifndef NUM_PROCS
`define NUM_PROCS 4
`endif

package read_feeder_pkg;

  localparam int MAX_STRING_LENGTH = `MAX_STRING_LENGTH;
  localparam int NUM_PROCS         = `NUM_PROCS;
  localparam int IDX_W             = $clog2(MAX_STRING_LENGTH);
  // Largest loadable pair; the length must still fit in an IDX_W-bit field.
  localparam int MAX_LEN           = (1 << IDX_W) - 1;
  localparam int BUF_DEPTH         = 1 << IDX_W;
  localparam int QUAL_W            = 8;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    STRING_A    = 3'd0,
    STRING_C    = 3'd1,
    STRING_G    = 3'd2,
    STRING_T    = 3'd3,
    STRING_DASH = 3'd4
  } STRING;

  typedef struct packed {
    logic                   valid;
    STRING                  reference;
    STRING [NUM_PROCS-1:0]  exp;
  } READS;

  typedef struct packed {
    logic                        valid;
    logic [NUM_PROCS-1:0][63:0]  match;
    logic [NUM_PROCS-1:0][63:0]  neq;
  } PRIORS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } feeder_state_t;

  // Probability that a base with phred quality q is wrong: 10^(-q/10).
  function automatic logic [63:0] neq_bits(input int q);
    return $realtobits(10.0 ** (-q / 10.0));
  endfunction

  // Probability that a base with phred quality q is right: 1 - 10^(-q/10).
  function automatic logic [63:0] match_bits(input int q);
    return $realtobits(1.0 - 10.0 ** (-q / 10.0));
  endfunction

endpackage

// File: rtl/read_feeder_if.sv
// read_feeder_if: load stream plus systolic_array request/response bus.
//   master - the side feeding loads and issuing read requests
//   slave  - read_feeder itself
// Load stream : load_valid/load_ready handshake with ref, exp, qual, last;
//               load_error flags a pair truncated at capacity.
// Array side  : sa_reset, string_length, x/y read requests, complete,
//               registered base_reads / prior_reads results.

interface read_feeder_if;
  import read_feeder_pkg::*;

  logic        load_valid;
  logic        load_ready;
  STRING       load_ref;
  STRING       load_exp;
  logic [7:0]  load_qual;
  logic        load_last;
  logic        load_error;

  logic        sa_reset;
  idx_t        string_length;
  idx_t        read_index_x;
  logic        read_x_valid;
  idx_t        read_index_y;
  logic        read_y_valid;
  logic        complete;
  READS        base_reads;
  PRIORS       prior_reads;

  modport master (
    output load_valid, load_ref, load_exp, load_qual, load_last,
    output read_index_x, read_x_valid, read_index_y, read_y_valid, complete,
    input  load_ready, load_error, sa_reset, string_length,
    input  base_reads, prior_reads
  );

  modport slave (
    input  load_valid, load_ref, load_exp, load_qual, load_last,
    input  read_index_x, read_x_valid, read_index_y, read_y_valid, complete,
    output load_ready, load_error, sa_reset, string_length,
    output base_reads, prior_reads
  );

endinterface

// File: rtl/read_feeder_phred_rom.sv
// phred_rom: combinational phred quality -> {match, neq} double-precision
// priors. The table is built at elaboration; entries past QUAL_MAX repeat
// the QUAL_MAX value so any QUAL_W-bit index is safe.
//   q_i     - clamped phred value
//   match_o - IEEE-754 bits of 1 - 10^(-q/10)
//   neq_o   - IEEE-754 bits of 10^(-q/10)

module phred_rom
  import read_feeder_pkg::*;
#(
  parameter int QUAL_MAX = 127
) (
  input  logic [QUAL_W-1:0] q_i,
  output logic [63:0]       match_o,
  output logic [63:0]       neq_o
);

  localparam int ENTRIES = 1 << QUAL_W;

  logic [63:0] match_tab [ENTRIES];
  logic [63:0] neq_tab   [ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_tab
      localparam int          QC        = (gi > QUAL_MAX) ? QUAL_MAX : gi;
      localparam logic [63:0] MATCH_VAL = match_bits(QC);
      localparam logic [63:0] NEQ_VAL   = neq_bits(QC);
      assign match_tab[gi] = MATCH_VAL;
      assign neq_tab[gi]   = NEQ_VAL;
    end
  endgenerate

  assign match_o = match_tab[q_i];
  assign neq_o   = neq_tab[q_i];

endmodule

// File: rtl/read_feeder.sv
// read_feeder: buffers one read pair (reference, experimental, quality) from a
// load stream, converts qualities to match/neq priors as they arrive, then
// serves systolic_array's x/y read requests with registered results.
//   clock, reset - system clock, synchronous active-high reset
//   bus (slave)  - load stream and systolic_array request/response signals
// The array is held in sa_reset until a complete pair sits in the buffers.

module read_feeder
  import read_feeder_pkg::*;
#(
  parameter int QUAL_MAX    = 127,
  parameter int QUAL_OFFSET = 0
) (
  input  logic          clock,
  input  logic          reset,
  read_feeder_if.slave  bus
);

  feeder_state_t state_q, state_d;
  idx_t          cnt_q, cnt_d;
  idx_t          len_q, len_d;
  logic          err_q, err_d;
  READS          base_q, base_d;
  PRIORS         prior_q, prior_d;

  // Pair storage; never cleared, only overwritten by the next load.
  STRING         ref_buf   [BUF_DEPTH];
  STRING         exp_buf   [BUF_DEPTH];
  logic [63:0]   match_buf [BUF_DEPTH];
  logic [63:0]   neq_buf   [BUF_DEPTH];

  logic          ready;
  logic          accept;
  idx_t          wr_idx;
  idx_t          next_idx;
  logic          at_cap;
  logic          truncate;
  logic          beat_last;

  int            q_full;
  logic [QUAL_W-1:0] q_clamp;
  logic [63:0]   rom_match;
  logic [63:0]   rom_neq;

  STRING         x_ref;
  STRING         lane_exp   [NUM_PROCS];
  logic [63:0]   lane_match [NUM_PROCS];
  logic [63:0]   lane_neq   [NUM_PROCS];

  // ---------------------------------------------------------------- load path
  assign ready    = (state_q != SERVE);
  assign accept   = bus.load_valid & ready;
  // The first beat of a pair always lands at position 0.
  assign wr_idx   = (state_q == IDLE) ? '0 : cnt_q;
  assign next_idx = wr_idx + idx_t'(1);
  // Writing the last slot ends the pair even without load_last.
  assign at_cap   = (wr_idx == idx_t'(MAX_LEN - 1));
  assign truncate = at_cap & ~bus.load_last;
  assign beat_last = bus.load_last | at_cap;

  always_comb begin
    q_full  = int'(bus.load_qual) - QUAL_OFFSET;
    q_clamp = '0;
    if (q_full < 0) begin
      q_clamp = '0;
    end else if (q_full > QUAL_MAX) begin
      q_clamp = QUAL_W'(QUAL_MAX);
    end else begin
      q_clamp = QUAL_W'(q_full);
    end
  end

  phred_rom #(
    .QUAL_MAX (QUAL_MAX)
  ) u_phred_rom (
    .q_i     (q_clamp),
    .match_o (rom_match),
    .neq_o   (rom_neq)
  );

  always_ff @(posedge clock) begin
    if (accept) begin
      ref_buf[wr_idx]   <= bus.load_ref;
      exp_buf[wr_idx]   <= bus.load_exp;
      match_buf[wr_idx] <= rom_match;
      neq_buf[wr_idx]   <= rom_neq;
    end
  end

  // --------------------------------------------------------------- serve path
  assign x_ref = (bus.read_index_x < len_q) ? ref_buf[bus.read_index_x] : STRING_DASH;

  // Each processor lane looks at base + lane; positions past the loaded
  // length read as a dash with zero priors. One extra index bit keeps the
  // window from wrapping back into valid data.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROCS; gi++) begin : g_lane
      logic [IDX_W:0] pos;
      logic           in_range;
      assign pos      = {1'b0, bus.read_index_y} + (IDX_W + 1)'(gi);
      assign in_range = (pos < {1'b0, len_q});
      assign lane_exp[gi]   = in_range ? exp_buf[pos[IDX_W-1:0]]   : STRING_DASH;
      assign lane_match[gi] = in_range ? match_buf[pos[IDX_W-1:0]] : 64'd0;
      assign lane_neq[gi]   = in_range ? neq_buf[pos[IDX_W-1:0]]   : 64'd0;
    end
  endgenerate

  // ---------------------------------------------------------- state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      base_q  <= '0;
      prior_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      base_q  <= base_d;
      prior_q <= prior_d;
    end
  end

  // ----------------------------------------------------- next state / outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    base_d  = base_q;
    prior_d = prior_q;

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          cnt_d = next_idx;
          if (state_q == IDLE) begin
            // A new pair starts: drop the previous pair's results and error.
            err_d   = 1'b0;
            base_d  = '0;
            prior_d = '0;
            state_d = LOAD;
          end
          if (truncate) begin
            err_d = 1'b1;
          end
          if (beat_last) begin
            state_d = SERVE;
            len_d   = next_idx;
          end
        end
      end

      SERVE: begin
        if (bus.read_x_valid) begin
          base_d.valid     = 1'b1;
          base_d.reference = x_ref;
        end
        if (bus.read_y_valid) begin
          prior_d.valid = 1'b1;
          for (int i = 0; i < NUM_PROCS; i++) begin
            base_d.exp[i]    = lane_exp[i];
            prior_d.match[i] = lane_match[i];
            prior_d.neq[i]   = lane_neq[i];
          end
        end
        if (bus.complete) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.load_ready    = ready;
  assign bus.sa_reset      = (state_q != SERVE);
  assign bus.load_error    = err_q;
  assign bus.string_length = len_q;
  assign bus.base_reads    = base_q;
  assign bus.prior_reads   = prior_q;

endmodule

// File: tb/tb_read_feeder.sv
// tb_read_feeder: self-checking bench for read_feeder. A vector table drives
// the main pair load; expected outputs are queued as stimulus is driven and
// compared after the clock edge that should produce them. Hand-written
// sequences cover truncation, complete, and reset in the middle of a load.

module tb_read_feeder;
  import read_feeder_pkg::*;

  localparam logic [63:0] N20 = 64'h3F847AE147AE147B;
  localparam logic [63:0] M20 = 64'h3FEFAE147AE147AE;
  localparam logic [63:0] N10 = 64'h3FB999999999999A;
  localparam logic [63:0] M10 = 64'h3FECCCCCCCCCCCCD;
  localparam logic [63:0] N0  = 64'h3FF0000000000000;
  localparam logic [63:0] M0  = 64'h0000000000000000;

  localparam int SEL_REF   = 0;
  localparam int SEL_BV    = 1;
  localparam int SEL_PV    = 2;
  localparam int SEL_LEN   = 3;
  localparam int SEL_ERR   = 4;
  localparam int SEL_SARST = 5;
  localparam int SEL_READY = 6;
  localparam int SEL_EXP   = 10;
  localparam int SEL_MATCH = 20;
  localparam int SEL_NEQ   = 30;

  logic clk;
  logic rst;

  read_feeder_if bus ();

  read_feeder #(
    .QUAL_MAX    (127),
    .QUAL_OFFSET (0)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    STRING       r;
    STRING       e;
    logic [7:0]  q;
    logic [63:0] want_match;
    logic [63:0] want_neq;
  } vec_t;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] want;
  } exp_t;

  vec_t        vecs [4];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;

  // Reference model of the pair the feeder should currently hold.
  STRING       m_ref   [BUF_DEPTH];
  STRING       m_exp   [BUF_DEPTH];
  logic [63:0] m_match [BUF_DEPTH];
  logic [63:0] m_neq   [BUF_DEPTH];
  int          m_len;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end else begin
      $display("[TB] ok %s = %h", tag, got);
    end
  endtask

  function automatic logic [63:0] field(input int sel);
    logic [63:0] v;
    v = '0;
    if (sel == SEL_REF)        v[2:0] = bus.base_reads.reference;
    else if (sel == SEL_BV)    v[0] = bus.base_reads.valid;
    else if (sel == SEL_PV)    v[0] = bus.prior_reads.valid;
    else if (sel == SEL_LEN)   v[IDX_W-1:0] = bus.string_length;
    else if (sel == SEL_ERR)   v[0] = bus.load_error;
    else if (sel == SEL_SARST) v[0] = bus.sa_reset;
    else if (sel == SEL_READY) v[0] = bus.load_ready;
    else if (sel >= SEL_EXP && sel < SEL_EXP + NUM_PROCS)
      v[2:0] = bus.base_reads.exp[sel - SEL_EXP];
    else if (sel >= SEL_MATCH && sel < SEL_MATCH + NUM_PROCS)
      v = bus.prior_reads.match[sel - SEL_MATCH];
    else if (sel >= SEL_NEQ && sel < SEL_NEQ + NUM_PROCS)
      v = bus.prior_reads.neq[sel - SEL_NEQ];
    return v;
  endfunction

  task automatic expect_f(input string tag, input int sel, input logic [63:0] want);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.want = want;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, field(e.sel), e.want);
    end
  endtask

  // Queue the expected y-window result for base index b.
  task automatic push_y(input string tag, input int b);
    for (int i = 0; i < NUM_PROCS; i++) begin
      int p;
      p = b + i;
      if (p < m_len) begin
        expect_f($sformatf("%s_exp%0d", tag, i),   SEL_EXP + i,   64'(m_exp[p]));
        expect_f($sformatf("%s_match%0d", tag, i), SEL_MATCH + i, m_match[p]);
        expect_f($sformatf("%s_neq%0d", tag, i),   SEL_NEQ + i,   m_neq[p]);
      end else begin
        expect_f($sformatf("%s_exp%0d", tag, i),   SEL_EXP + i,   64'(STRING_DASH));
        expect_f($sformatf("%s_match%0d", tag, i), SEL_MATCH + i, 64'd0);
        expect_f($sformatf("%s_neq%0d", tag, i),   SEL_NEQ + i,   64'd0);
      end
    end
    expect_f({tag, "_pvalid"}, SEL_PV, 64'd1);
  endtask

  task automatic idle_inputs();
    bus.load_valid   = 1'b0;
    bus.load_ref     = STRING_A;
    bus.load_exp     = STRING_A;
    bus.load_qual    = 8'd0;
    bus.load_last    = 1'b0;
    bus.read_index_x = '0;
    bus.read_x_valid = 1'b0;
    bus.read_index_y = '0;
    bus.read_y_valid = 1'b0;
    bus.complete     = 1'b0;
  endtask

  task automatic drive_beat(input STRING r, input STRING e, input logic [7:0] q, input logic last);
    bus.load_valid = 1'b1;
    bus.load_ref   = r;
    bus.load_exp   = e;
    bus.load_qual  = q;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic pulse_complete();
    bus.complete = 1'b1;
    tick();
    bus.complete = 1'b0;
  endtask

  initial begin
    int acc;

    vecs[0] = '{STRING_A, STRING_G, 8'd20, M20, N20};
    vecs[1] = '{STRING_C, STRING_A, 8'd10, M10, N10};
    vecs[2] = '{STRING_G, STRING_T, 8'd0,  M0,  N0};
    vecs[3] = '{STRING_T, STRING_C, 8'd20, M20, N20};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    expect_f("rst_ready",  SEL_READY, 64'd1);
    expect_f("rst_sarst",  SEL_SARST, 64'd1);
    expect_f("rst_err",    SEL_ERR,   64'd0);
    expect_f("rst_len",    SEL_LEN,   64'd0);
    expect_f("rst_bvalid", SEL_BV,    64'd0);
    expect_f("rst_pvalid", SEL_PV,    64'd0);
    drain();
    rst = 1'b0;

    // Requests outside SERVE are ignored
    bus.read_x_valid = 1'b1;
    bus.read_y_valid = 1'b1;
    expect_f("idle_req_bvalid", SEL_BV, 64'd0);
    expect_f("idle_req_pvalid", SEL_PV, 64'd0);
    tick();
    bus.read_x_valid = 1'b0;
    bus.read_y_valid = 1'b0;
    drain();

    // Main pair from the vector table, with a gap (and a stray complete) mid-load
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.complete = 1'b1;
        tick();
        bus.complete = 1'b0;
        expect_f("gap_ready", SEL_READY, 64'd1);
        expect_f("gap_sarst", SEL_SARST, 64'd1);
        drain();
      end
      if (i == 3) begin
        expect_f("pre_serve_sarst", SEL_SARST, 64'd1);
        drain();
      end
      drive_beat(vecs[i].r, vecs[i].e, vecs[i].q, (i == 3));
      m_ref[i]   = vecs[i].r;
      m_exp[i]   = vecs[i].e;
      m_match[i] = vecs[i].want_match;
      m_neq[i]   = vecs[i].want_neq;
    end
    m_len = 4;
    expect_f("serve_sarst", SEL_SARST, 64'd0);
    expect_f("serve_ready", SEL_READY, 64'd0);
    expect_f("serve_len",   SEL_LEN,   64'd4);
    expect_f("serve_err",   SEL_ERR,   64'd0);
    drain();

    // Full window from 0
    bus.read_y_valid = 1'b1;
    bus.read_index_y = idx_t'(0);
    push_y("y0", 0);
    tick();
    bus.read_y_valid = 1'b0;
    drain();

    // x and y together, window running off the end
    bus.read_x_valid = 1'b1;
    bus.read_index_x = idx_t'(2);
    bus.read_y_valid = 1'b1;
    bus.read_index_y = idx_t'(3);
    expect_f("x2_ref",    SEL_REF, 64'(STRING_G));
    expect_f("x2_bvalid", SEL_BV,  64'd1);
    push_y("y3", 3);
    tick();
    bus.read_x_valid = 1'b0;
    bus.read_y_valid = 1'b0;
    drain();

    // x past the end; y fields hold
    bus.read_x_valid = 1'b1;
    bus.read_index_x = idx_t'(4);
    expect_f("x4_ref",     SEL_REF,     64'(STRING_DASH));
    expect_f("hold_exp0",  SEL_EXP,     64'(m_exp[3]));
    expect_f("hold_neq0",  SEL_NEQ,     m_neq[3]);
    tick();
    bus.read_x_valid = 1'b0;
    drain();

    // complete -> IDLE, outputs retained, requests ignored again
    pulse_complete();
    expect_f("cmp_sarst",  SEL_SARST, 64'd1);
    expect_f("cmp_ready",  SEL_READY, 64'd1);
    expect_f("cmp_len",    SEL_LEN,   64'd4);
    expect_f("cmp_bvalid", SEL_BV,    64'd1);
    drain();
    bus.read_x_valid = 1'b1;
    bus.read_index_x = idx_t'(0);
    expect_f("idle2_ref_hold", SEL_REF, 64'(STRING_DASH));
    tick();
    bus.read_x_valid = 1'b0;
    drain();

    // Truncation: MAX_LEN+3 beats with no load_last
    acc = 0;
    for (int i = 0; i < MAX_LEN + 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_ref   = STRING'(i % 4);
      bus.load_exp   = STRING'((i + 1) % 4);
      bus.load_qual  = 8'd10;
      bus.load_last  = 1'b0;
      if (bus.load_ready) begin
        m_ref[acc]   = STRING'(i % 4);
        m_exp[acc]   = STRING'((i + 1) % 4);
        m_match[acc] = M10;
        m_neq[acc]   = N10;
        acc++;
      end
      tick();
      if (i == 0) begin
        expect_f("newload_bvalid", SEL_BV, 64'd0);
        expect_f("newload_pvalid", SEL_PV, 64'd0);
        drain();
      end
    end
    bus.load_valid = 1'b0;
    m_len = MAX_LEN;
    check("trunc_accepted", 64'(acc), 64'(MAX_LEN));
    expect_f("trunc_err",   SEL_ERR,   64'd1);
    expect_f("trunc_len",   SEL_LEN,   64'(MAX_LEN));
    expect_f("trunc_ready", SEL_READY, 64'd0);
    expect_f("trunc_sarst", SEL_SARST, 64'd0);
    drain();

    bus.read_x_valid = 1'b1;
    bus.read_index_x = idx_t'(MAX_LEN - 1);
    bus.read_y_valid = 1'b1;
    bus.read_index_y = idx_t'(MAX_LEN - 3);
    expect_f("xlast_ref", SEL_REF, 64'(m_ref[MAX_LEN - 1]));
    push_y("ytail", MAX_LEN - 3);
    tick();
    bus.read_x_valid = 1'b0;
    bus.read_y_valid = 1'b0;
    drain();
    pulse_complete();

    // Reset in the middle of a load, then a fresh 3-beat pair
    drive_beat(STRING_T, STRING_T, 8'd0, 1'b0);
    drive_beat(STRING_T, STRING_T, 8'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_f("midrst_ready", SEL_READY, 64'd1);
    expect_f("midrst_sarst", SEL_SARST, 64'd1);
    expect_f("midrst_len",   SEL_LEN,   64'd0);
    expect_f("midrst_err",   SEL_ERR,   64'd0);
    expect_f("midrst_pvalid", SEL_PV,   64'd0);
    drain();

    for (int i = 0; i < 3; i++) begin
      drive_beat(vecs[i + 1].r, vecs[i + 1].e, vecs[i + 1].q, (i == 2));
      m_ref[i]   = vecs[i + 1].r;
      m_exp[i]   = vecs[i + 1].e;
      m_match[i] = vecs[i + 1].want_match;
      m_neq[i]   = vecs[i + 1].want_neq;
    end
    m_len = 3;
    expect_f("fresh_len",   SEL_LEN,   64'd3);
    expect_f("fresh_err",   SEL_ERR,   64'd0);
    expect_f("fresh_sarst", SEL_SARST, 64'd0);
    drain();

    bus.read_y_valid = 1'b1;
    bus.read_index_y = idx_t'(0);
    bus.read_x_valid = 1'b1;
    bus.read_index_x = idx_t'(0);
    expect_f("fresh_x0", SEL_REF, 64'(m_ref[0]));
    push_y("fresh_y0", 0);
    tick();
    bus.read_y_valid = 1'b0;
    bus.read_x_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
